// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// Radix-2 restoring iteration on magnitudes; signs are fixed up when the
// result is registered. busy_o holds the ID->EX register while a divide runs.
// Optional build macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed overflow
// skip the iteration and finish one cycle after launch.
//
//   state  | meaning
//   IDLE   | waiting for a divide-class op in EX (start_i)
//   CALC   | one restoring step per cycle, DATA_WIDTH steps
//   DONE   | result_o/valid_o presented; pipeline advances
module ex_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  rem_sel_q, rem_sel_d;   // 1: REM/REMU, 0: DIV/DIVU
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic                  dz_q, dz_d;             // divisor was zero
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  valid_q, valid_d;

    logic                  is_signed;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] step_q, step_r, fin_res;

    assign is_signed = ~op_i[0];
    assign abs_a = (is_signed & rs1_i[DATA_WIDTH-1]) ? -rs1_i : rs1_i;
    assign abs_b = (is_signed & rs2_i[DATA_WIDTH-1]) ? -rs2_i : rs2_i;

    // One restoring step: trial subtract of the divisor from the shifted remainder.
    assign trial  = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, div_q};
    assign step_r = trial[DATA_WIDTH] ? {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]}
                                      : trial[DATA_WIDTH-1:0];
    assign step_q = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

    // Signed overflow needs no override: |min|/1 already yields min with remainder 0.
    assign fin_res = rem_sel_q ? (negr_q ? -step_r : step_r)
                               : (dz_q ? ONES : (negq_q ? -step_q : step_q));

`ifdef DIV_EARLY_OUT_EN
    logic                  launch_ovf, launch_early;
    logic [DATA_WIDTH-1:0] early_res;
    assign launch_ovf   = is_signed & (rs1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (rs2_i == ONES);
    assign launch_early = (rs2_i == '0) | launch_ovf;
    assign early_res    = (rs2_i == '0) ? (op_i[1] ? rs1_i : ONES)
                                        : (op_i[1] ? '0 : rs1_i);
`endif

    // Next-state, datapath and stall logic.
    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dz_d      = dz_q;
        div_d     = div_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    busy_o    = 1'b1;
                    rem_sel_d = op_i[1];
                    negq_d    = is_signed & (rs1_i[DATA_WIDTH-1] ^ rs2_i[DATA_WIDTH-1]);
                    negr_d    = is_signed & rs1_i[DATA_WIDTH-1];
                    dz_d      = (rs2_i == '0);
                    div_d     = abs_b;
                    quo_d     = abs_a;
                    rem_d     = '0;
                    cnt_d     = CW'(DATA_WIDTH - 1);
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (launch_early) begin
                        state_d  = S_DONE;
                        result_d = early_res;
                        valid_d  = 1'b1;
                    end
`endif
                end
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (!start_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = step_q;
                    rem_d = step_r;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = fin_res;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            dz_q      <= 1'b0;
            div_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            dz_q      <= dz_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed RV32M cases, back-to-back,
// abort, mid-operation reset and random operands against an arithmetic model.
module tb_ex_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_exp = 32'h0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_div_unit #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE (b2b=0) or DONE (b2b=1).
    // Returns #1 after the edge that enters DONE, start_i still high.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit b2b);
        int n, lat;
        bit busy_ok;
        logic [31:0] exp;
        exp     = ref_res(op, a, b);
        lat     = (EARLY && is_special(op, a, b)) ? 1 : 33;
        if (b2b) lat += 1;
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        #1;
        chk({tag, "_busy0"}, {31'h0, busy_o}, b2b ? 32'h0 : 32'h1);
        busy_ok = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_o) break;
            if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'h1);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_busydone"}, {31'h0, busy_o}, 32'h0);
        last_exp = exp;
    endtask

    // Drop start_i after DONE and confirm IDLE with no relaunch or extra pulse.
    task automatic idle_step(input string tag);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_novalid"}, {31'h0, valid_o}, 32'h0);
        chk({tag, "_hold"}, result_o, last_exp);
    endtask

    initial begin
        int seen;
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'd0;
        rs1_i   = 32'h0;
        rs2_i   = 32'h0;
        #2;
        chk("rst_result", result_o, 32'h0);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_busy0", {31'h0, busy_o}, 32'h0);
        start_i = 1'b1;
        #1;
        chk("rst_busy1", {31'h0, busy_o}, 32'h1);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("divu_100_7", 2'd1, 32'd100, 32'd7, 1'b0);        idle_step("i1");
        do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);        idle_step("i2");
        do_op("div_m7_2", 2'd0, -32'sd7, 32'd2, 1'b0);          idle_step("i3");
        do_op("rem_m7_2", 2'd2, -32'sd7, 32'd2, 1'b0);          idle_step("i4");
        do_op("rem_7_m2", 2'd2, 32'd7, -32'sd2, 1'b0);          idle_step("i5");
        do_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle_step("i6");
        do_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle_step("i7");
        do_op("divu_z", 2'd1, 32'h1234, 32'h0, 1'b0);           idle_step("i8");
        do_op("rem_z", 2'd2, 32'h1234, 32'h0, 1'b0);            idle_step("i9");
        do_op("div_m5_z", 2'd0, -32'sd5, 32'h0, 1'b0);          idle_step("i10");
        do_op("remu_z_neg", 2'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);  idle_step("i11");

        do_op("b2b_a", 2'd1, 32'd9, 32'd3, 1'b0);
        do_op("b2b_b", 2'd3, 32'd9, 32'd4, 1'b1);
        idle_step("i12");

        // Abort: drop start_i in CALC cycle 5.
        start_i = 1'b1; op_i = 2'd1; rs1_i = 32'd5000; rs2_i = 32'd13;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        #1;
        chk("abort_busy5", {31'h0, busy_o}, 32'h1);
        @(posedge clk);
        #1;
        chk("abort_busy6", {31'h0, busy_o}, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        chk("abort_novalid", seen, 0);
        chk("abort_hold", result_o, last_exp);

        // Reset in CALC cycle 10.
        start_i = 1'b1; op_i = 2'd1; rs1_i = 32'd1000; rs2_i = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rstmid_result", result_o, 32'h0);
        chk("rstmid_valid", {31'h0, valid_o}, 32'h0);
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        chk("rstmid_novalid", seen, 0);
        last_exp = 32'h0;
        chk("rstmid_hold", result_o, last_exp);

        // Random operands, occasionally special, occasionally back-to-back.
        for (int k = 0; k < 24; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            bit          chain;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            chain = (k != 0) && ($urandom_range(0, 2) == 0);
            if (!chain && k != 0) idle_step("rnd_idle");
            do_op("rnd", rop, ra, rb, chain);
        end
        idle_step("end_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
